tlb_test_register: RTL
======================

Name: tlb_test_register

Overview:
- Parametrised test-register file that generalises the TR0–TR7 bank, with byte-strobed writes and configurable register count and width.
- Adds a TLB test sequencer. A write to the command register (TR6 role) launches a TLB write or lookup through a valid/ready request channel.
- Lookup results and hit status are captured into the data register (TR7 role).
- Sits beside the paging unit. Driven by MOV TRn microcode; its requests go to the TLB test port.

Parameters:
- DATA_WIDTH, 32, register width in bits; multiple of 8, ≥16.
- REG_COUNT, 8, number of registers; ≥2, power of two.
- CMD_INDEX, 6, index of the command register; < REG_COUNT.
- DATA_INDEX, 7, index of the data register; < REG_COUNT, ≠ CMD_INDEX.
- TIMEOUT, 15, maximum cycles spent in WAIT before abort; 1..255.

Ports:
- clock  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- write_enable  input  1  register write request.
- write_index  input  $clog2(REG_COUNT)  target register.
- write_data  input  DATA_WIDTH  write data.
- write_strobe  input  DATA_WIDTH/8  byte enables; bit k covers data[8k+7:8k].
- TR  output  DATA_WIDTH x REG_COUNT  register contents, array [0:REG_COUNT-1].
- busy  output  1  sequencer not IDLE.
- write_dropped  output  1  one-cycle pulse when a write is discarded.
- tlb_req_valid  output  1  request valid.
- tlb_req_ready  input  1  TLB accepts the request.
- tlb_req_lookup  output  1  1 = lookup, 0 = TLB write (copy of CMD bit 0).
- tlb_req_cmd  output  DATA_WIDTH  snapshot of the command register.
- tlb_req_data  output  DATA_WIDTH  snapshot of the data register.
- tlb_rsp_valid  input  1  lookup response valid, single cycle.
- tlb_rsp_hit  input  1  lookup hit.
- tlb_rsp_data  input  DATA_WIDTH  lookup result (physical address, REP).
- timeout_error  output  1  sticky; set on lookup timeout, cleared by the next command launch.

Behaviour:
- Reset: all TR = 0, FSM = IDLE, busy = 0, tlb_req_valid = 0, snapshots = 0, timeout_error = 0, write_dropped = 0. Reset mid-operation aborts immediately; no response is expected afterwards. A tlb_rsp_valid arriving in IDLE is ignored.
- Register write: when write_enable is high, each byte with its strobe set is updated on the next edge. All-zero strobe = no-op; no launch, no drop.
- Non-CMD/DATA registers are writable in every state.
- Writes to CMD_INDEX or DATA_INDEX while busy = 1 are discarded and pulse write_dropped for one cycle.
- IDLE: a write to CMD_INDEX with any strobe bit set updates the register and, on the same edge:
  - FSM goes to REQ;
  - tlb_req_cmd/tlb_req_data capture the post-write CMD value and the current DATA value;
  - timeout_error clears.
- Launch latency: tlb_req_valid rises in the cycle after the CMD write edge.
- REQ: tlb_req_valid = 1; valid, lookup, cmd and data stay stable until tlb_req_ready.
  - On a handshake edge with lookup = 0 (TLB write): go to IDLE; busy drops the next cycle.
  - On a handshake edge with lookup = 1: go to WAIT and clear the wait counter.
- WAIT: the counter increments each cycle.
  - On tlb_rsp_valid: TR[DATA_INDEX] <= tlb_rsp_data with bit 4 (HT) replaced by tlb_rsp_hit; go to IDLE.
  - If the counter reaches TIMEOUT with no response: TR[DATA_INDEX] bit 4 <= 0 (other bits kept), timeout_error <= 1, go to IDLE.
  - A response and the timeout in the same cycle: the response wins.
- busy = (state ≠ IDLE).
- A response-capture edge coinciding with a DATA write: the write is dropped (busy), the capture wins.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state.

Test Plan:
- Reset, then write idx 3 = 0xDEADBEEF with strobe 0xF, then idx 3 = 0x00001200 with strobe 0x2 -> TR[3] = 0xDEAD12EF, busy stays 0, no tlb_req_valid.
- Write DATA = 0x12345678, then CMD = 0xABCDE000 (C = 0); hold ready low 2 cycles -> valid high 3 cycles with lookup = 0, cmd = 0xABCDE000, data = 0x12345678; after the handshake busy = 0 next cycle.
- CMD = 0xABCDE001 (lookup); ready immediate; rsp_valid 4 cycles later with hit = 1, data = 0x55555000 -> TR[7] = 0x55555010, timeout_error = 0, busy clears.
- Lookup with no response -> exactly TIMEOUT cycles in WAIT, then TR[7] bit 4 = 0, timeout_error = 1; the next CMD write clears timeout_error.
- While busy: write idx 6 and idx 7 -> both unchanged, write_dropped pulses once each; write idx 2 = 0x1 -> TR[2] = 0x1.
- Assert reset during WAIT -> all TR = 0, busy = 0; a late rsp_valid leaves TR[7] = 0.

Source files
------------

// File: rtl/tlb_test_register.sv
`default_nettype none
// ============================================================================
// Module   : tlb_test_register
// Purpose  : Parametrised TR0..TRn test-register bank with byte-strobed
//            writes, plus a small sequencer that turns a write of the command
//            register into a TLB write or lookup request. Lookup results and
//            hit status land in the data register.
// Ports    : clock/reset          - rising-edge clock, async active-high reset
//            write_*              - register write port (index, data, strobes)
//            TR                   - register contents, array [0:REG_COUNT-1]
//            busy                 - sequencer not idle
//            write_dropped        - one-cycle pulse when a write is discarded
//            tlb_req_*            - valid/ready request channel to TLB test port
//            tlb_rsp_*            - single-cycle lookup response
//            timeout_error        - sticky lookup-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module tlb_test_register #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 8,
  parameter int CMD_INDEX  = 6,
  parameter int DATA_INDEX = 7,
  parameter int TIMEOUT    = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         write_enable,
  input  logic [$clog2(REG_COUNT)-1:0] write_index,
  input  logic [DATA_WIDTH-1:0]        write_data,
  input  logic [DATA_WIDTH/8-1:0]      write_strobe,
  output logic [DATA_WIDTH-1:0]        TR [0:REG_COUNT-1],
  output logic                         busy,
  output logic                         write_dropped,
  output logic                         tlb_req_valid,
  input  logic                         tlb_req_ready,
  output logic                         tlb_req_lookup,
  output logic [DATA_WIDTH-1:0]        tlb_req_cmd,
  output logic [DATA_WIDTH-1:0]        tlb_req_data,
  input  logic                         tlb_rsp_valid,
  input  logic                         tlb_rsp_hit,
  input  logic [DATA_WIDTH-1:0]        tlb_rsp_data,
  output logic                         timeout_error
);

  localparam int              IW       = $clog2(REG_COUNT);
  localparam int              STRB_W   = DATA_WIDTH / 8;
  localparam logic [IW-1:0]   CMD_IDX  = IW'(CMD_INDEX);
  localparam logic [IW-1:0]   DATA_IDX = IW'(DATA_INDEX);
  localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);
  localparam int              HT_BIT   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tr_q [0:REG_COUNT-1];
  logic [DATA_WIDTH-1:0] tr_d [0:REG_COUNT-1];
  logic [DATA_WIDTH-1:0] req_cmd_q, req_cmd_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic                  timeout_q, timeout_d;
  logic                  dropped_q, dropped_d;

  logic                  wr_any;
  logic                  wr_protected;
  logic                  wr_accept;
  logic [DATA_WIDTH-1:0] wr_merged;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

  // An all-zero strobe is a no-op everywhere: it neither launches nor drops.
  assign wr_any       = write_enable && (|write_strobe);
  // CMD/DATA belong to the sequencer while it is busy.
  assign wr_protected = (write_index == CMD_IDX) || (write_index == DATA_IDX);
  assign wr_accept    = wr_any && !(busy && wr_protected);
  assign wr_merged    = merge_bytes(tr_q[write_index], write_data, write_strobe);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_cmd_d  = req_cmd_q;
    req_data_d = req_data_q;
    timeout_d  = timeout_q;
    dropped_d  = wr_any && busy && wr_protected;
    tr_d       = tr_q;

    if (wr_accept) tr_d[write_index] = wr_merged;

    case (state_q)
      S_IDLE: begin
        if (wr_any && (write_index == CMD_IDX)) begin
          state_d    = S_REQ;
          req_cmd_d  = wr_merged;
          req_data_d = tr_q[DATA_INDEX];
          timeout_d  = 1'b0;
        end
      end
      S_REQ: begin
        if (tlb_req_ready) begin
          state_d = req_cmd_q[0] ? S_WAIT : S_IDLE;
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Response is checked first so it wins over a same-cycle timeout.
        if (tlb_rsp_valid) begin
          tr_d[DATA_INDEX]         = tlb_rsp_data;
          tr_d[DATA_INDEX][HT_BIT] = tlb_rsp_hit;
          state_d                  = S_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          tr_d[DATA_INDEX][HT_BIT] = 1'b0;
          timeout_d                = 1'b1;
          state_d                  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      req_cmd_q  <= '0;
      req_data_q <= '0;
      timeout_q  <= 1'b0;
      dropped_q  <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) tr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_cmd_q  <= req_cmd_d;
      req_data_q <= req_data_d;
      timeout_q  <= timeout_d;
      dropped_q  <= dropped_d;
      for (int i = 0; i < REG_COUNT; i++) tr_q[i] <= tr_d[i];
    end
  end

  assign TR             = tr_q;
  assign busy           = (state_q != S_IDLE);
  assign tlb_req_valid  = (state_q == S_REQ);
  assign tlb_req_lookup = req_cmd_q[0];
  assign tlb_req_cmd    = req_cmd_q;
  assign tlb_req_data   = req_data_q;
  assign timeout_error  = timeout_q;
  assign write_dropped  = dropped_q;

endmodule
`default_nettype wire
